// File: rtl/fetch_stage_if.sv
// Instruction-memory request/acknowledge channel between the fetch stage and IMEM.
interface fetch_stage_if #(
    parameter int unsigned PC_W = 16
);
    logic            IMEM_Req;
    logic [PC_W-1:0] IMEM_Addr;
    logic            IMEM_Ack;
    logic [15:0]     IMEM_Data;

    modport master (
        output IMEM_Req,
        output IMEM_Addr,
        input  IMEM_Ack,
        input  IMEM_Data
    );

    modport slave (
        input  IMEM_Req,
        input  IMEM_Addr,
        output IMEM_Ack,
        output IMEM_Data
    );
endinterface

// File: rtl/fetch_stage.sv
// Pipeline fetch stage: PC, IMEM request FSM with one-entry hold buffer, and IF/ID register.
module fetch_stage #(
    parameter int unsigned     PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              PC_Hold,
    input  logic              IF_ID_Hold,
    input  logic              Branch_Taken,
    input  logic [PC_W-1:0]   Branch_Target,
    fetch_stage_if.master     imem,
    output logic [15:0]       IF_ID_Instr,
    output logic [PC_W-1:0]   IF_ID_PC1,
    output logic              IF_ID_Valid,
    output logic [2:0]        IF_ID_RS,
    output logic [2:0]        IF_ID_RT
);
    typedef enum logic [1:0] {FETCH, BUFFERED, DRAIN} state_e;

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [PC_W-1:0]   drain_addr_q, drain_addr_d;
    logic [15:0]       buf_q, buf_d;
    logic [15:0]       instr_q, instr_d;
    logic [PC_W-1:0]   pc1_q, pc1_d;
    logic              valid_q, valid_d;

    logic              hold;
    logic [PC_W-1:0]   pc_inc;

    assign hold   = PC_Hold | IF_ID_Hold;
    assign pc_inc = pc_q + PC_W'(1);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        buf_d        = buf_q;
        instr_d      = instr_q;
        pc1_d        = pc1_q;
        valid_d      = valid_q;

        unique case (state_q)
            FETCH: begin
                if (Branch_Taken) begin
                    pc_d    = Branch_Target;
                    valid_d = 1'b0;
                    // An unacknowledged request must complete at its old address first.
                    if (!imem.IMEM_Ack) begin
                        drain_addr_d = pc_q;
                        state_d      = DRAIN;
                    end
                end else if (imem.IMEM_Ack) begin
                    if (hold) begin
                        buf_d   = imem.IMEM_Data;
                        state_d = BUFFERED;
                    end else begin
                        instr_d = imem.IMEM_Data;
                        pc1_d   = pc_inc;
                        valid_d = 1'b1;
                        pc_d    = pc_inc;
                    end
                end
            end
            BUFFERED: begin
                if (Branch_Taken) begin
                    pc_d    = Branch_Target;
                    valid_d = 1'b0;
                    state_d = FETCH;
                end else if (!hold) begin
                    instr_d = buf_q;
                    pc1_d   = pc_inc;
                    valid_d = 1'b1;
                    pc_d    = pc_inc;
                    state_d = FETCH;
                end
            end
            DRAIN: begin
                if (Branch_Taken) begin
                    pc_d    = Branch_Target;
                    valid_d = 1'b0;
                end
                if (imem.IMEM_Ack) begin
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            drain_addr_q <= '0;
            buf_q        <= '0;
            instr_q      <= '0;
            pc1_q        <= '0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            buf_q        <= buf_d;
            instr_q      <= instr_d;
            pc1_q        <= pc1_d;
            valid_q      <= valid_d;
        end
    end

    assign imem.IMEM_Req  = (state_q != BUFFERED);
    assign imem.IMEM_Addr = (state_q == DRAIN) ? drain_addr_q : pc_q;

    assign IF_ID_Instr = instr_q;
    assign IF_ID_PC1   = pc1_q;
    assign IF_ID_Valid = valid_q;
    assign IF_ID_RS    = valid_q ? instr_q[11:9] : 3'd0;
    assign IF_ID_RT    = valid_q ? instr_q[8:6]  : 3'd0;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: inputs change and outputs are checked on the falling edge.
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        PC_Hold;
    logic        IF_ID_Hold;
    logic        Branch_Taken;
    logic [15:0] Branch_Target;
    logic [15:0] IF_ID_Instr;
    logic [15:0] IF_ID_PC1;
    logic        IF_ID_Valid;
    logic [2:0]  IF_ID_RS;
    logic [2:0]  IF_ID_RT;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    fetch_stage_if #(.PC_W(16)) imem_if ();

    fetch_stage #(.PC_W(16), .RESET_PC(16'h0000)) dut (
        .clk           (clk),
        .rst           (rst),
        .PC_Hold       (PC_Hold),
        .IF_ID_Hold    (IF_ID_Hold),
        .Branch_Taken  (Branch_Taken),
        .Branch_Target (Branch_Target),
        .imem          (imem_if.master),
        .IF_ID_Instr   (IF_ID_Instr),
        .IF_ID_PC1     (IF_ID_PC1),
        .IF_ID_Valid   (IF_ID_Valid),
        .IF_ID_RS      (IF_ID_RS),
        .IF_ID_RT      (IF_ID_RT)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic ack, input logic [15:0] data, input logic ph,
                         input logic ih, input logic br, input logic [15:0] tgt);
        imem_if.IMEM_Ack  = ack;
        imem_if.IMEM_Data = data;
        PC_Hold           = ph;
        IF_ID_Hold        = ih;
        Branch_Taken      = br;
        Branch_Target     = tgt;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
        step(); step();
        chk("rst_valid", 32'(IF_ID_Valid), 32'd0);
        chk("rst_instr", 32'(IF_ID_Instr), 32'h0);
        chk("rst_pc1",   32'(IF_ID_PC1),   32'h0);
        chk("rst_addr",  32'(imem_if.IMEM_Addr), 32'h0);
        rst = 1'b0;
        step();
        chk("post_rst_req", 32'(imem_if.IMEM_Req), 32'd1);

        // Streaming fetch of addresses 0..4
        for (int i = 0; i < 5; i++) begin
            chk("stream_addr", 32'(imem_if.IMEM_Addr), 32'(i));
            drive(1'b1, 16'h1000 + 16'(i), 1'b0, 1'b0, 1'b0, 16'h0000);
            step();
            chk("stream_instr", 32'(IF_ID_Instr), 32'h1000 + 32'(i));
            chk("stream_pc1",   32'(IF_ID_PC1),   32'(i + 1));
            chk("stream_valid", 32'(IF_ID_Valid), 32'd1);
        end

        // Ack for addr 5 under hold, then two more held cycles with a stray Ack
        chk("hold_addr5", 32'(imem_if.IMEM_Addr), 32'h5);
        drive(1'b1, 16'h1005, 1'b1, 1'b1, 1'b0, 16'h0000);
        step();
        chk("buf_req0",  32'(imem_if.IMEM_Req), 32'd0);
        chk("buf_instr", 32'(IF_ID_Instr), 32'h1004);
        chk("buf_pc1",   32'(IF_ID_PC1),   32'h5);
        drive(1'b1, 16'hBEEF, 1'b1, 1'b1, 1'b0, 16'h0000);
        step();
        chk("buf_req0_b",  32'(imem_if.IMEM_Req), 32'd0);
        chk("buf_instr_b", 32'(IF_ID_Instr), 32'h1004);
        chk("buf_valid_b", 32'(IF_ID_Valid), 32'd1);
        drive(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000);
        step();
        chk("buf_instr_c", 32'(IF_ID_Instr), 32'h1004);
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
        step();
        chk("unbuf_instr", 32'(IF_ID_Instr), 32'h1005);
        chk("unbuf_pc1",   32'(IF_ID_PC1),   32'h6);
        chk("unbuf_req",   32'(imem_if.IMEM_Req), 32'd1);
        chk("unbuf_addr",  32'(imem_if.IMEM_Addr), 32'h6);

        // Hold with no Ack leaves everything alone
        drive(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000);
        step();
        chk("noack_hold_addr",  32'(imem_if.IMEM_Addr), 32'h6);
        chk("noack_hold_instr", 32'(IF_ID_Instr), 32'h1005);
        drive(1'b1, 16'h1006, 1'b0, 1'b0, 1'b0, 16'h0000);
        step();
        chk("addr6_instr", 32'(IF_ID_Instr), 32'h1006);
        chk("addr7_addr",  32'(imem_if.IMEM_Addr), 32'h7);

        // Redirect while the addr-7 request is outstanding
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0040);
        step();
        chk("drain_req",   32'(imem_if.IMEM_Req), 32'd1);
        chk("drain_addr",  32'(imem_if.IMEM_Addr), 32'h7);
        chk("drain_valid", 32'(IF_ID_Valid), 32'd0);
        chk("drain_instr", 32'(IF_ID_Instr), 32'h1006);
        chk("drain_rs",    32'(IF_ID_RS), 32'd0);
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
        step();
        chk("drain_addr_stable", 32'(imem_if.IMEM_Addr), 32'h7);
        drive(1'b1, 16'h1007, 1'b0, 1'b0, 1'b0, 16'h0000);
        step();
        chk("drained_addr",  32'(imem_if.IMEM_Addr), 32'h40);
        chk("drained_valid", 32'(IF_ID_Valid), 32'd0);
        chk("drained_instr", 32'(IF_ID_Instr), 32'h1006);

        // RS/RT decode of 16'h0AC0
        drive(1'b1, 16'h0AC0, 1'b0, 1'b0, 1'b0, 16'h0000);
        step();
        chk("rs_dec",   32'(IF_ID_RS), 32'd5);
        chk("rt_dec",   32'(IF_ID_RT), 32'd3);
        chk("pc1_41",   32'(IF_ID_PC1), 32'h41);

        // Ack + hold + redirect together: redirect wins
        drive(1'b1, 16'h1234, 1'b1, 1'b1, 1'b1, 16'hFFFF);
        step();
        chk("prio_valid", 32'(IF_ID_Valid), 32'd0);
        chk("prio_rs",    32'(IF_ID_RS), 32'd0);
        chk("prio_rt",    32'(IF_ID_RT), 32'd0);
        chk("prio_req",   32'(imem_if.IMEM_Req), 32'd1);
        chk("prio_addr",  32'(imem_if.IMEM_Addr), 32'hFFFF);
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
        step();
        chk("prio_bufempty_instr", 32'(IF_ID_Instr), 32'h0AC0);
        chk("prio_bufempty_valid", 32'(IF_ID_Valid), 32'd0);

        // PC wrap at 16'hFFFF
        drive(1'b1, 16'h5A5A, 1'b0, 1'b0, 1'b0, 16'h0000);
        step();
        chk("wrap_instr", 32'(IF_ID_Instr), 32'h5A5A);
        chk("wrap_pc1",   32'(IF_ID_PC1),   32'h0);
        chk("wrap_addr",  32'(imem_if.IMEM_Addr), 32'h0);

        // Redirect out of BUFFERED discards the buffer
        drive(1'b1, 16'h1111, 1'b0, 1'b1, 1'b0, 16'h0000);
        step();
        chk("buf2_req", 32'(imem_if.IMEM_Req), 32'd0);
        drive(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0020);
        step();
        chk("bufbr_req",   32'(imem_if.IMEM_Req), 32'd1);
        chk("bufbr_addr",  32'(imem_if.IMEM_Addr), 32'h20);
        chk("bufbr_valid", 32'(IF_ID_Valid), 32'd0);
        drive(1'b1, 16'h2222, 1'b0, 1'b0, 1'b0, 16'h0000);
        step();
        chk("bufbr_instr", 32'(IF_ID_Instr), 32'h2222);
        chk("bufbr_pc1",   32'(IF_ID_PC1),   32'h21);

        // Second redirect while draining
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0030);
        step();
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0050);
        step();
        chk("drain2_addr", 32'(imem_if.IMEM_Addr), 32'h21);
        chk("drain2_req",  32'(imem_if.IMEM_Req), 32'd1);
        drive(1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b0, 16'h0000);
        step();
        chk("drain2_newaddr", 32'(imem_if.IMEM_Addr), 32'h50);
        chk("drain2_instr",   32'(IF_ID_Instr), 32'h2222);

        // Reset overrides a simultaneous redirect
        rst = 1'b1;
        drive(1'b1, 16'h3333, 1'b1, 1'b0, 1'b1, 16'h0077);
        step();
        chk("rst2_addr",  32'(imem_if.IMEM_Addr), 32'h0);
        chk("rst2_valid", 32'(IF_ID_Valid), 32'd0);
        chk("rst2_instr", 32'(IF_ID_Instr), 32'h0);
        rst = 1'b0;
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
        step();
        chk("rst2_req", 32'(imem_if.IMEM_Req), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
